// File: rtl/bht_update_gen_pkg.sv
// Shared types and helpers for the BHT update producer.
// - cva6_cfg_t / cva6_cfg_empty : minimal core configuration (RVC selects the
//   PC offset and the number of instructions per fetch).
// - bht_update_t : {valid, pc, taken} update sent to the BHT.
// - bht_entry_t  : {pc, taken} record buffered in the update FIFO.
// - prediction_bits() : PC bit count that spans the BHT row and bank. The BHT
//   uses the same function so both sides agree on the entry a PC maps to.
package bht_update_gen_pkg;

    localparam int VLEN = 32;

    typedef struct packed {
        logic rvc;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{rvc: 1'b1};

    typedef struct packed {
        logic            valid;
        logic [VLEN-1:0] pc;
        logic            taken;
    } bht_update_t;

    typedef struct packed {
        logic [VLEN-1:0] pc;
        logic            taken;
    } bht_entry_t;

    function automatic int instr_per_fetch(cva6_cfg_t cfg);
        return cfg.rvc ? 2 : 1;
    endfunction

    function automatic int pc_offset(cva6_cfg_t cfg);
        return cfg.rvc ? 1 : 2;
    endfunction

    function automatic int prediction_bits(cva6_cfg_t cfg, int nr_entries);
        return $clog2(nr_entries / instr_per_fetch(cfg)) + pc_offset(cfg)
               + $clog2(instr_per_fetch(cfg));
    endfunction

endpackage

// File: rtl/bht_update_gen_fifo.sv
// Small FIFO holding pending BHT updates, with first-word-fall-through head.
// Ports:
//   clk, srst      : clock and synchronous active-high reset
//   flush          : discard all contents (pointers and count cleared)
//   push, data_in  : write one entry (ignored when full unless popping too)
//   pop, data_out  : remove the head entry; data_out always shows the head
//   full, empty, count : occupancy status
module bht_update_fifo
    import bht_update_gen_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     flush,
    input  logic                     push,
    input  bht_entry_t               data_in,
    input  logic                     pop,
    output bht_entry_t               data_out,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    bht_entry_t         mem [DEPTH];
    logic [PW-1:0]      wr_ptr_reg;
    logic [PW-1:0]      rd_ptr_reg;
    logic [PW:0]        count_reg;
    logic               push_ok;
    logic               pop_ok;

    assign full     = (count_reg == (PW+1)'(DEPTH));
    assign empty    = (count_reg == '0);
    assign count    = count_reg;
    assign data_out = mem[rd_ptr_reg];

    // When full, a write is only legal if the head leaves in the same cycle.
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (srst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/bht_update_gen.sv
// Producer of BHT updates. Resolved conditional branches are buffered and
// issued one per cycle in order; an update whose BHT entry matches the one
// issued in the previous cycle waits one bubble cycle so the BHT's
// read-modify-write sees the committed value.
// Ports:
//   clk_i, rst_i       : clock, synchronous active-high reset
//   flush_i            : drop everything queued
//   debug_mode_i       : resolves in debug mode are ignored
//   resolve_*_i        : resolved instruction from the branch unit
//   bht_update_o       : registered {valid, pc, taken} towards the BHT
//   drop_cnt_o         : saturating count of updates lost to overflow
module bht_update_gen
    import bht_update_gen_pkg::*;
#(
    parameter cva6_cfg_t CVA6Cfg      = cva6_cfg_empty,
    parameter int        NR_ENTRIES   = 1024,
    parameter int        DEPTH        = 4,
    parameter int        HAZARD_STALL = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            debug_mode_i,
    input  logic            resolve_valid_i,
    input  logic            resolve_is_cond_i,
    input  logic [VLEN-1:0] resolve_pc_i,
    input  logic            resolve_taken_i,
    output bht_update_t     bht_update_o,
    output logic [7:0]      drop_cnt_o
);

    localparam int OFFSET = pc_offset(CVA6Cfg);
    localparam int PB     = prediction_bits(CVA6Cfg, NR_ENTRIES);
    localparam int IDX_W  = PB - OFFSET;
    localparam int CW     = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        HOLD
    } state_t;

    state_t             state_reg;
    bht_update_t        out_reg;
    logic [IDX_W-1:0]   last_idx_reg;
    logic               last_idx_valid_reg;
    logic [7:0]         drop_cnt_reg;

    bht_entry_t         incoming;
    bht_entry_t         fifo_head;
    bht_entry_t         head;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CW-1:0]      fifo_count;
    logic               fifo_push;
    logic               fifo_pop;
    logic               enq_req;
    logic               avail;
    logic               hazard;
    logic               deq;
    logic               bypass;
    logic               drop;
    logic [IDX_W-1:0]   head_idx;

    assign enq_req  = resolve_valid_i && resolve_is_cond_i && !debug_mode_i && !flush_i;
    assign incoming = '{pc: resolve_pc_i, taken: resolve_taken_i};

    // An empty FIFO lets the incoming resolve go straight to the output register.
    assign head     = fifo_empty ? incoming : fifo_head;
    assign avail    = (fifo_count != '0) || enq_req;
    assign head_idx = head.pc[PB-1:OFFSET];

    // Only an update issued in the immediately preceding cycle can conflict,
    // so a HOLD cycle clears the condition and never repeats.
    assign hazard = (HAZARD_STALL != 0) && (state_reg == ISSUE) && last_idx_valid_reg
                    && (head_idx == last_idx_reg);

    assign deq       = avail && !hazard && !flush_i;
    assign bypass    = fifo_empty && enq_req && deq;
    assign fifo_push = enq_req && !bypass && (!fifo_full || deq);
    assign fifo_pop  = deq && !fifo_empty;
    assign drop      = enq_req && fifo_full && !deq;

    bht_update_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk_i),
        .srst     (rst_i),
        .flush    (flush_i),
        .push     (fifo_push),
        .data_in  (incoming),
        .pop      (fifo_pop),
        .data_out (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg          <= IDLE;
            out_reg            <= '0;
            last_idx_reg       <= '0;
            last_idx_valid_reg <= 1'b0;
        end else if (flush_i) begin
            state_reg          <= IDLE;
            out_reg.valid      <= 1'b0;
            last_idx_valid_reg <= 1'b0;
        end else if (deq) begin
            state_reg          <= ISSUE;
            out_reg            <= '{valid: 1'b1, pc: head.pc, taken: head.taken};
            last_idx_reg       <= head_idx;
            last_idx_valid_reg <= 1'b1;
        end else begin
            state_reg          <= avail ? HOLD : IDLE;
            out_reg.valid      <= 1'b0;
            last_idx_valid_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            drop_cnt_reg <= '0;
        end else if (drop && (drop_cnt_reg != 8'hFF)) begin
            drop_cnt_reg <= drop_cnt_reg + 8'd1;
        end
    end

    assign bht_update_o = out_reg;
    assign drop_cnt_o   = drop_cnt_reg;

endmodule
